// File: rtl/axis_resp_checker.sv
// AXI-Stream response checker: compares each accepted beat against a masked gold RAM,
// applies a programmable tready pattern and reports error counts, framing and cycle stats.
module axis_resp_checker #(
  parameter int unsigned NUM_PE     = 8,
  parameter int unsigned ACT_BW     = 16,
  parameter int unsigned GOLD_DEPTH = 4096,
  parameter int unsigned GOLD_AW    = $clog2(GOLD_DEPTH),
  parameter int unsigned CNT_BW     = 32,
  parameter int unsigned BP_BW      = 8
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic                       start,
  input  logic [GOLD_AW:0]           num_resp,
  input  logic [15:0]                resp_per_tstep,
  input  logic [BP_BW-1:0]           bp_pattern,
  input  logic                       gold_we,
  input  logic [GOLD_AW-1:0]         gold_waddr,
  input  logic [NUM_PE*ACT_BW-1:0]   gold_wdata,
  input  logic [NUM_PE*ACT_BW-1:0]   gold_wmask,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [NUM_PE*ACT_BW-1:0]   s_axis_tdata,
  input  logic                       s_axis_tlast,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [CNT_BW-1:0]          mismatch_cnt,
  output logic [CNT_BW-1:0]          tlast_err_cnt,
  output logic [GOLD_AW:0]           first_err_idx,
  output logic [NUM_PE-1:0]          first_err_lanes,
  output logic [CNT_BW-1:0]          timestep,
  output logic [CNT_BW-1:0]          cycle_cnt
);

  localparam int unsigned DW    = NUM_PE * ACT_BW;
  localparam int unsigned IW    = GOLD_AW + 1;
  localparam int unsigned BP_SW = $clog2(BP_BW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       r_num_resp;
  logic [15:0]         r_rpt;
  logic [15:0]         r_tstep_pos;
  logic [BP_BW-1:0]    r_bp;
  logic                r_pass;
  logic [CNT_BW-1:0]   r_mismatch_cnt;
  logic [CNT_BW-1:0]   r_tlast_err_cnt;
  logic [IW-1:0]       r_first_err_idx;
  logic [NUM_PE-1:0]   r_first_err_lanes;
  logic [CNT_BW-1:0]   r_timestep;
  logic [CNT_BW-1:0]   r_cycle_cnt;

  logic [2*DW-1:0]     r_gold_mem [GOLD_DEPTH];
  logic [2*DW-1:0]     r_gold_q;

  logic                w_run;
  logic                w_tready;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_last_beat;
  logic                w_tstep_end;
  logic                w_tlast_bad;
  logic                w_beat_fail;
  logic [NUM_PE-1:0]   w_lane_fail;
  logic [DW-1:0]       w_gold_data;
  logic [DW-1:0]       w_gold_mask;
  logic [GOLD_AW-1:0]  w_rd_addr;

  function automatic logic [CNT_BW-1:0] sat_inc(input logic [CNT_BW-1:0] v);
    return (&v) ? v : v + CNT_BW'(1);
  endfunction

  assign w_run       = (r_state == S_RUN);
  assign w_tready    = w_run & r_bp[r_cycle_cnt[BP_SW-1:0]];
  assign w_accept    = s_axis_tvalid & w_tready;
  assign w_start_ok  = start & ~w_run;
  assign w_last_beat = (r_idx == r_num_resp - IW'(1));
  assign w_tstep_end = (r_tstep_pos == r_rpt - 16'd1);
  assign w_tlast_bad = (s_axis_tlast != w_tstep_end);
  assign w_gold_data = r_gold_q[DW-1:0];
  assign w_gold_mask = r_gold_q[2*DW-1:DW];
  assign w_beat_fail = |w_lane_fail;

  // Prefetch the next entry on accept so r_gold_q always holds gold[idx]
  assign w_rd_addr = w_start_ok ? '0 :
                     w_accept   ? GOLD_AW'(r_idx + IW'(1)) : GOLD_AW'(r_idx);

  always_ff @(posedge s_axi_aclk) begin
    if (gold_we && !w_run) begin
      r_gold_mem[gold_waddr] <= {gold_wmask, gold_wdata};
    end
    r_gold_q <= r_gold_mem[w_rd_addr];
  end

  always_comb begin
    w_lane_fail = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      w_lane_fail[i] = |((s_axis_tdata[i*ACT_BW +: ACT_BW] ^ w_gold_data[i*ACT_BW +: ACT_BW])
                         & ~w_gold_mask[i*ACT_BW +: ACT_BW]);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state           <= S_IDLE;
      r_idx             <= '0;
      r_num_resp        <= '0;
      r_rpt             <= '0;
      r_tstep_pos       <= '0;
      r_bp              <= '0;
      r_pass            <= 1'b0;
      r_mismatch_cnt    <= '0;
      r_tlast_err_cnt   <= '0;
      r_first_err_idx   <= '1;
      r_first_err_lanes <= '0;
      r_timestep        <= '0;
      r_cycle_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_idx             <= '0;
            r_num_resp        <= num_resp;
            r_rpt             <= (resp_per_tstep == 16'd0) ? 16'd1 : resp_per_tstep;
            r_tstep_pos       <= '0;
            r_bp              <= bp_pattern;
            r_mismatch_cnt    <= '0;
            r_tlast_err_cnt   <= '0;
            r_first_err_idx   <= '1;
            r_first_err_lanes <= '0;
            r_timestep        <= '0;
            r_cycle_cnt       <= '0;
            // An empty run completes immediately and trivially passes
            if (num_resp == '0) begin
              r_state <= S_DONE;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_cycle_cnt <= sat_inc(r_cycle_cnt);
          if (w_accept) begin
            r_idx <= r_idx + IW'(1);
            if (w_beat_fail) begin
              r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
              if (r_mismatch_cnt == '0) begin
                r_first_err_idx   <= r_idx;
                r_first_err_lanes <= w_lane_fail;
              end
            end
            if (w_tlast_bad) begin
              r_tlast_err_cnt <= sat_inc(r_tlast_err_cnt);
            end
            if (w_tstep_end) begin
              r_tstep_pos <= '0;
              r_timestep  <= sat_inc(r_timestep);
            end else begin
              r_tstep_pos <= r_tstep_pos + 16'd1;
            end
            if (w_last_beat) begin
              r_state <= S_DONE;
              r_pass  <= (r_mismatch_cnt == '0) & ~w_beat_fail &
                         (r_tlast_err_cnt == '0) & ~w_tlast_bad;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axis_tready   = w_tready;
  assign busy            = w_run;
  assign done            = (r_state == S_DONE);
  assign pass            = r_pass;
  assign mismatch_cnt    = r_mismatch_cnt;
  assign tlast_err_cnt   = r_tlast_err_cnt;
  assign first_err_idx   = r_first_err_idx;
  assign first_err_lanes = r_first_err_lanes;
  assign timestep        = r_timestep;
  assign cycle_cnt       = r_cycle_cnt;

endmodule

// File: tb/tb_axis_resp_checker.sv
// Directed bench for axis_resp_checker: a reference model predicts each run's result record,
// which is queued at start and compared when done rises.
module tb_axis_resp_checker;

  localparam int unsigned NUM_PE = 8;
  localparam int unsigned ACT_BW = 16;
  localparam int unsigned DW     = NUM_PE * ACT_BW;
  localparam int unsigned GAW    = 12;
  localparam int unsigned N      = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [GAW:0]    num_resp = '0;
  logic [15:0]     resp_per_tstep = '0;
  logic [7:0]      bp_pattern = '0;
  logic            gold_we = 1'b0;
  logic [GAW-1:0]  gold_waddr = '0;
  logic [DW-1:0]   gold_wdata = '0;
  logic [DW-1:0]   gold_wmask = '0;
  logic            tvalid = 1'b0;
  logic            tready;
  logic [DW-1:0]   tdata = '0;
  logic            tlast = 1'b0;
  logic            busy, done, pass;
  logic [31:0]     mismatch_cnt, tlast_err_cnt, timestep, cycle_cnt;
  logic [GAW:0]    first_err_idx;
  logic [7:0]      first_err_lanes;

  typedef struct {
    int          mism;
    int          tlerr;
    logic [GAW:0] fidx;
    logic [7:0]  flanes;
    int          ts;
    int          cyc_cnt;
    int          done_cyc;
    logic        pass;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] g_d [N];
  logic [DW-1:0] g_m [N];
  logic [DW-1:0] r_d [N];
  logic          r_last [N];
  int            n_vec = 0;
  int            n_fail = 0;

  axis_resp_checker dut (
    .s_axi_aclk      (clk),
    .s_axi_aresetn   (rst_n),
    .start           (start),
    .num_resp        (num_resp),
    .resp_per_tstep  (resp_per_tstep),
    .bp_pattern      (bp_pattern),
    .gold_we         (gold_we),
    .gold_waddr      (gold_waddr),
    .gold_wdata      (gold_wdata),
    .gold_wmask      (gold_wmask),
    .s_axis_tvalid   (tvalid),
    .s_axis_tready   (tready),
    .s_axis_tdata    (tdata),
    .s_axis_tlast    (tlast),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .mismatch_cnt    (mismatch_cnt),
    .tlast_err_cnt   (tlast_err_cnt),
    .first_err_idx   (first_err_idx),
    .first_err_lanes (first_err_lanes),
    .timestep        (timestep),
    .cycle_cnt       (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_gold(input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    @(negedge clk);
    gold_we = 1'b1; gold_waddr = GAW'(a); gold_wdata = d; gold_wmask = m;
    g_d[a] = d; g_m[a] = m;
    @(negedge clk);
    gold_we = 1'b0;
  endtask

  task automatic set_tlast(input int rpt);
    for (int b = 0; b < N; b++) r_last[b] = ((b % rpt) == rpt - 1);
  endtask

  // Reference prediction of one run's final status
  function automatic exp_t model(input int n, input int rpt, input logic [7:0] bp, input int pre);
    exp_t e;
    logic [DW-1:0] x;
    logic [7:0] lanes;
    int pos, c, k;
    e.mism = 0; e.tlerr = 0; e.fidx = '1; e.flanes = '0; e.ts = 0; pos = 0;
    for (int b = 0; b < n; b++) begin
      x = (r_d[b] ^ g_d[b]) & ~g_m[b];
      lanes = '0;
      for (int l = 0; l < NUM_PE; l++) lanes[l] = |x[l*ACT_BW +: ACT_BW];
      if (lanes != 0) begin
        if (e.mism == 0) begin e.fidx = (GAW+1)'(b); e.flanes = lanes; end
        e.mism++;
      end
      if (r_last[b] != (pos == rpt - 1)) e.tlerr++;
      if (pos == rpt - 1) begin pos = 0; e.ts++; end else pos++;
    end
    c = 0; k = 0;
    while (k < n && c < 900) begin
      if (c >= pre && bp[c % 8]) k++;
      c++;
    end
    e.cyc_cnt = c;
    e.done_cyc = c + 1;
    e.pass = (e.mism == 0) && (e.tlerr == 0);
    return e;
  endfunction

  task automatic run(input string nm, input int n, input int rpt, input logic [7:0] bp,
                     input int pre, input bit intrude);
    exp_t e;
    int cyc, k, p;
    logic acc;
    sb.push_back(model(n, rpt, bp, pre));
    @(negedge clk);
    num_resp = (GAW+1)'(n); resp_per_tstep = 16'(rpt); bp_pattern = bp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; k = 0; p = 0;
    while (!done && cyc < 1000) begin
      if (intrude && p == 1) begin
        gold_we = 1'b1; gold_waddr = GAW'(7); gold_wdata = ~g_d[7]; gold_wmask = '0;
        start = 1'b1; num_resp = (GAW+1)'(1);
      end else begin
        gold_we = 1'b0; start = 1'b0;
      end
      if (p < pre) begin
        tvalid = 1'b0; p++;
      end else if (k < n) begin
        tvalid = 1'b1; tdata = r_d[k]; tlast = r_last[k];
      end else begin
        tvalid = 1'b0;
      end
      acc = tvalid & tready;
      @(negedge clk);
      cyc++;
      if (acc) k++;
    end
    gold_we = 1'b0; start = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    e = sb.pop_front();
    check({nm, "_done"},      64'(done), 64'(1));
    check({nm, "_done_cyc"},  64'(cyc), 64'(e.done_cyc));
    check({nm, "_cycle_cnt"}, 64'(cycle_cnt), 64'(e.cyc_cnt));
    check({nm, "_mism"},      64'(mismatch_cnt), 64'(e.mism));
    check({nm, "_tlast_err"}, 64'(tlast_err_cnt), 64'(e.tlerr));
    check({nm, "_fidx"},      64'(first_err_idx), 64'(e.fidx));
    check({nm, "_flanes"},    64'(first_err_lanes), 64'(e.flanes));
    check({nm, "_timestep"},  64'(timestep), 64'(e.ts));
    check({nm, "_pass"},      64'(pass), 64'(e.pass));
    check({nm, "_busy"},      64'(busy), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tready", 64'(tready), 64'(0));
    check("rst_done",   64'(done), 64'(0));
    check("rst_busy",   64'(busy), 64'(0));
    check("rst_pass",   64'(pass), 64'(0));
    check("rst_fidx",   64'(first_err_idx), 64'(13'h1FFF));
    check("rst_mism",   64'(mismatch_cnt), 64'(0));
    rst_n = 1'b1;

    for (int a = 0; a < N; a++) begin
      write_gold(a, {$urandom(), $urandom(), $urandom(), $urandom()}, '0);
      r_d[a] = g_d[a];
    end
    set_tlast(4);

    run("match", N, 4, 8'hFF, 0, 1'b0);

    r_d[5] = g_d[5] ^ (128'h1 << 48);
    run("lane3", N, 4, 8'hFF, 0, 1'b0);

    write_gold(5, g_d[5], 128'h1 << 48);
    run("masked", N, 4, 8'hFF, 0, 1'b0);

    r_last[2] = 1'b1; r_last[3] = 1'b0;
    run("tlast", N, 4, 8'hFF, 0, 1'b0);
    set_tlast(4);
    r_d[5] = g_d[5];

    run("bp55", N, 4, 8'h55, 0, 1'b0);

    run("intrude", N, 4, 8'hFF, 3, 1'b1);

    // Abort a run that already has an error recorded
    r_d[0] = g_d[0] ^ 128'h1;
    @(negedge clk);
    num_resp = (GAW+1)'(N); resp_per_tstep = 16'd4; bp_pattern = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; tvalid = 1'b1; tdata = r_d[0]; tlast = r_last[0];
    @(negedge clk);
    tdata = r_d[1]; tlast = r_last[1];
    @(negedge clk);
    tvalid = 1'b0;
    check("mid_busy", 64'(busy), 64'(1));
    check("mid_mism", 64'(mismatch_cnt), 64'(1));
    check("mid_cyc",  64'(cycle_cnt), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   64'(busy), 64'(0));
    check("abort_done",   64'(done), 64'(0));
    check("abort_tready", 64'(tready), 64'(0));
    check("abort_mism",   64'(mismatch_cnt), 64'(0));
    check("abort_cyc",    64'(cycle_cnt), 64'(0));
    check("abort_ts",     64'(timestep), 64'(0));
    check("abort_fidx",   64'(first_err_idx), 64'(13'h1FFF));
    @(negedge clk);
    rst_n = 1'b1;
    r_d[0] = g_d[0];

    @(negedge clk);
    num_resp = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 64'(done), 64'(1));
    check("zero_pass", 64'(pass), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));

    run("after", N, 2, 8'hFF, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
